// File: rtl/interrupt_sequencer_if.sv
// rtl/interrupt_sequencer_if.sv - memory bus and PC/SP/STAT write ports driven by the interrupt sequencer
interface interrupt_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  data_in;
  logic [REG_WIDTH-1:0]  data_out;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  we_pc;
  logic [REG_WIDTH-1:0]  sp_out;
  logic                  we_sp;
  logic [REG_WIDTH-1:0]  status_out;
  logic                  we_stat;

  // Sequencer side: owns the bus and register write ports while busy
  modport master (
    output addr, data_out, mem_we, mem_re,
    output pc_out, we_pc, sp_out, we_sp, status_out, we_stat,
    input  data_in
  );

  // Memory / register file side
  modport slave (
    input  addr, data_out, mem_we, mem_re,
    input  pc_out, we_pc, sp_out, we_sp, status_out, we_stat,
    output data_in
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 6502 reset/NMI/IRQ/BRK entry sequencer (stack pushes, vector fetch, PC load)
module interrupt_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    REG_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE   = 16'h0100,
  parameter logic [ADDR_WIDTH-1:0] NMI_VECTOR   = 16'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR   = 16'hFFFE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rdy,
  input  logic                  irq_n,
  input  logic                  nmi_n,
  input  logic                  brk_req,
  input  logic                  instruction_done,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  sp_in,
  input  logic [REG_WIDTH-1:0]  status_in,
  output logic                  busy,
  output logic [1:0]            source,
  interrupt_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC
  } state_t;

  typedef enum logic [1:0] {
    SRC_IRQ   = 2'b00,
    SRC_BRK   = 2'b01,
    SRC_NMI   = 2'b10,
    SRC_RESET = 2'b11
  } source_t;

  localparam logic [REG_WIDTH-1:0] FLAG_I     = REG_WIDTH'(8'h04);
  localparam logic [REG_WIDTH-1:0] FLAG_B     = REG_WIDTH'(8'h10);
  localparam logic [REG_WIDTH-1:0] FLAG_U     = REG_WIDTH'(8'h20);
  localparam logic [REG_WIDTH-1:0] REG_ONE    = REG_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  source_t               source_q, source_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;          // PC to be pushed (already +1 for BRK)
  logic [REG_WIDTH-1:0]  sp_q, sp_d;          // working stack pointer
  logic [REG_WIDTH-1:0]  status_q, status_d;  // P captured at acceptance
  logic [ADDR_WIDTH-1:0] vector_q, vector_d;  // vector low-byte address
  logic [REG_WIDTH-1:0]  pcl_q, pcl_d;
  logic [REG_WIDTH-1:0]  pch_q, pch_d;
  logic                  nmi_prev_q;
  logic                  nmi_pending_q, nmi_pending_d;

  logic                  nmi_edge;
  logic                  is_reset_seq;
  logic [ADDR_WIDTH-1:0] stack_addr;
  logic [REG_WIDTH-1:0]  pushed_p;
  logic                  take;

  assign nmi_edge     = nmi_prev_q & ~nmi_n;
  assign is_reset_seq = (source_q == SRC_RESET);
  assign stack_addr   = STACK_BASE | {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, sp_q};
  // BRK pushes B set; hardware interrupts push B clear. Bit 5 always reads as 1.
  assign pushed_p     = (source_q == SRC_BRK) ? (status_q | FLAG_U | FLAG_B)
                                              : ((status_q | FLAG_U) & ~FLAG_B);

  assign busy   = reset | (state_q != IDLE);
  assign source = reset ? SRC_RESET : source_q;

  // State and datapath registers; reset parks the machine at the start of the reset sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= PUSH_PCH;
      source_q      <= SRC_RESET;
      pc_q          <= pc_in;
      sp_q          <= sp_in;
      status_q      <= status_in;
      vector_q      <= '0;
      pcl_q         <= '0;
      pch_q         <= '0;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      source_q      <= source_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      status_q      <= status_d;
      vector_q      <= vector_d;
      pcl_q         <= pcl_d;
      pch_q         <= pch_d;
      nmi_prev_q    <= nmi_n;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  // Next-state and bus/register-port outputs; every non-IDLE step waits for rdy
  always_comb begin
    state_d       = state_q;
    source_d      = source_q;
    pc_d          = pc_q;
    sp_d          = sp_q;
    status_d      = status_q;
    vector_d      = vector_q;
    pcl_d         = pcl_q;
    pch_d         = pch_q;
    nmi_pending_d = nmi_pending_q | nmi_edge;
    take          = 1'b0;

    bus.addr       = '0;
    bus.data_out   = '0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.pc_out     = '0;
    bus.we_pc      = 1'b0;
    bus.sp_out     = '0;
    bus.we_sp      = 1'b0;
    bus.status_out = '0;
    bus.we_stat    = 1'b0;

    case (state_q)
      IDLE: begin
        if (instruction_done) begin
          if (nmi_pending_q) begin
            take     = 1'b1;
            source_d = SRC_NMI;
          end else if (brk_req) begin
            take     = 1'b1;
            source_d = SRC_BRK;
          end else if (!irq_n && !status_in[2]) begin
            take     = 1'b1;
            source_d = SRC_IRQ;
          end
          if (take) begin
            state_d  = PUSH_PCH;
            // BRK returns past its padding byte
            pc_d     = (source_d == SRC_BRK) ? (pc_in + ADDR_ONE) : pc_in;
            sp_d     = sp_in;
            status_d = status_in;
          end
        end
      end

      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        // Reset runs the same cycles as dummy reads with nothing driven
        bus.addr   = stack_addr;
        bus.mem_we = rdy & ~is_reset_seq;
        bus.mem_re = rdy & is_reset_seq;
        if (!is_reset_seq) begin
          case (state_q)
            PUSH_PCH: bus.data_out = pc_q[ADDR_WIDTH-1 -: REG_WIDTH];
            PUSH_PCL: bus.data_out = pc_q[REG_WIDTH-1:0];
            default:  bus.data_out = pushed_p;
          endcase
        end
        if (state_q == PUSH_P) begin
          bus.sp_out     = sp_q - REG_ONE;
          bus.we_sp      = rdy;
          bus.status_out = status_q | FLAG_I;
          bus.we_stat    = rdy;
        end
        if (rdy) begin
          sp_d = sp_q - REG_ONE;
          case (state_q)
            PUSH_PCH: state_d = PUSH_PCL;
            PUSH_PCL: state_d = PUSH_P;
            default: begin
              state_d = VEC_LO;
              // A pending NMI hijacks a BRK/IRQ entry; the pushed P is left as is
              if (is_reset_seq) begin
                vector_d = RESET_VECTOR;
              end else if (source_q == SRC_NMI || nmi_pending_q) begin
                vector_d      = NMI_VECTOR;
                nmi_pending_d = nmi_edge;
              end else begin
                vector_d = IRQ_VECTOR;
              end
            end
          endcase
        end
      end

      VEC_LO: begin
        bus.addr   = vector_q;
        bus.mem_re = rdy;
        if (rdy) begin
          pcl_d   = bus.data_in;
          state_d = VEC_HI;
        end
      end

      VEC_HI: begin
        bus.addr   = vector_q + ADDR_ONE;
        bus.mem_re = rdy;
        if (rdy) begin
          pch_d   = bus.data_in;
          state_d = LOAD_PC;
        end
      end

      LOAD_PC: begin
        bus.pc_out = {pch_q, pcl_q};
        bus.we_pc  = rdy;
        if (rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing leaves the block while reset is held
    if (reset) begin
      bus.addr       = '0;
      bus.data_out   = '0;
      bus.mem_we     = 1'b0;
      bus.mem_re     = 1'b0;
      bus.pc_out     = '0;
      bus.we_pc      = 1'b0;
      bus.sp_out     = '0;
      bus.we_sp      = 1'b0;
      bus.status_out = '0;
      bus.we_stat    = 1'b0;
    end
  end

endmodule
